// File: rtl/hartslag_pkg.sv
// hartslag_pkg: shared types and helpers for the heartbeat pulse filter.
// Holds the debounce FSM state encoding and the counter width helper.
package hartslag_pkg;

  typedef enum logic [1:0] {
    LAAG      = 2'd0,
    NAAR_HOOG = 2'd1,
    HOOG      = 2'd2,
    NAAR_LAAG = 2'd3
  } fase_t;

  // Bits needed to hold values 0..n; never less than one bit.
  function automatic int cw(input int n);
    if (n < 1)
      return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hartslag_puls_filter_if.sv
// hartslag_puls_filter_if: sensor line in, conditioned beat signals out.
// slave is the filter side, master the consumer/stimulus side.
interface hartslag_puls_filter_if #(
  parameter int INTERVAL_W = 28
);

  logic                  Ingang;
  logic                  Puls;
  logic                  Niveau;
  logic                  Verworpen;
  logic [INTERVAL_W-1:0] Interval;
  logic                  IntervalGeldig;

  modport master (
    output Ingang,
    input  Puls,
    input  Niveau,
    input  Verworpen,
    input  Interval,
    input  IntervalGeldig
  );

  modport slave (
    input  Ingang,
    output Puls,
    output Niveau,
    output Verworpen,
    output Interval,
    output IntervalGeldig
  );

endinterface

// File: rtl/hartslag_puls_filter_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for one async bit.
// Both flops clear to 0 on synchronous reset.
module sync_2ff (
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hartslag_puls_filter.sv
// hartslag_puls_filter: sync, debounce and refractory gate for beats.
// Optional beat interval measurement under `HARTSLAG_INTERVAL_EN.
module hartslag_puls_filter
  import hartslag_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int REFRACT_CYC  = 12_500_000,
  parameter int INTERVAL_W   = 28
) (
  input logic                   CLK,
  input logic                   Reset,
  hartslag_puls_filter_if.slave bus
);

  localparam int DW = cw(DEBOUNCE_CYC);
  localparam int RW = cw(REFRACT_CYC);

  localparam logic [DW-1:0] DC_END = DW'(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DC_ONE = DW'(1);
  localparam logic [RW-1:0] RF_LD  = RW'(REFRACT_CYC);

  logic          s;
  fase_t         fase;
  logic [DW-1:0] dc;
  logic [RW-1:0] refr;
  logic          puls_r;
  logic          niv_r;
  logic          verw_r;
  logic          stijg;
  logic          acc;

  sync_2ff u_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .d     (bus.Ingang),
    .q     (s)
  );

  // Debounced rising edge this cycle, and whether it is accepted.
  always_comb begin
    stijg = 1'b0;
    acc   = 1'b0;
    if (fase == NAAR_HOOG && s && dc == DC_END)
      stijg = 1'b1;
    if (stijg && refr == '0)
      acc = 1'b1;
  end

  // Debounce FSM, refractory counter and registered event outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      fase   <= LAAG;
      dc     <= '0;
      refr   <= '0;
      puls_r <= 1'b0;
      niv_r  <= 1'b0;
      verw_r <= 1'b0;
    end else begin
      puls_r <= 1'b0;
      verw_r <= 1'b0;
      if (refr != '0)
        refr <= refr - RW'(1);
      unique case (fase)
        LAAG: begin
          if (s) begin
            fase <= NAAR_HOOG;
            dc   <= DC_ONE;
          end
        end
        NAAR_HOOG: begin
          if (!s) begin
            fase <= LAAG;
          end else if (dc == DC_END) begin
            fase  <= HOOG;
            niv_r <= 1'b1;
            if (acc) begin
              puls_r <= 1'b1;
              refr   <= RF_LD;
            end else begin
              verw_r <= 1'b1;
            end
          end else begin
            dc <= dc + DW'(1);
          end
        end
        HOOG: begin
          if (!s) begin
            fase <= NAAR_LAAG;
            dc   <= DC_ONE;
          end
        end
        NAAR_LAAG: begin
          if (s) begin
            fase <= HOOG;
          end else if (dc == DC_END) begin
            fase  <= LAAG;
            niv_r <= 1'b0;
          end else begin
            dc <= dc + DW'(1);
          end
        end
      endcase
    end
  end

  assign bus.Puls      = puls_r;
  assign bus.Niveau    = niv_r;
  assign bus.Verworpen = verw_r;

`ifdef HARTSLAG_INTERVAL_EN

  logic [INTERVAL_W-1:0] cnt;
  logic [INTERVAL_W-1:0] iv;
  logic                  ig;
  logic                  seen;
  logic [INTERVAL_W-1:0] cnt_sat;

  // Next count value, pinned at all-ones.
  always_comb begin
    cnt_sat = cnt;
    if (cnt != '1)
      cnt_sat = cnt + INTERVAL_W'(1);
  end

  // Beat-to-beat interval capture; first beat only arms it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt  <= '0;
      iv   <= '0;
      ig   <= 1'b0;
      seen <= 1'b0;
    end else begin
      ig <= 1'b0;
      if (acc) begin
        iv   <= cnt_sat;
        cnt  <= '0;
        ig   <= seen;
        seen <= 1'b1;
      end else begin
        cnt <= cnt_sat;
      end
    end
  end

  assign bus.Interval       = iv;
  assign bus.IntervalGeldig = ig;

`else

  assign bus.Interval       = {INTERVAL_W{1'b0}};
  assign bus.IntervalGeldig = 1'b0;

`endif

endmodule

// File: tb/tb_hartslag_puls_filter.sv
// tb_hartslag_puls_filter: directed scenario bench for the pulse filter.
// Uses DEBOUNCE_CYC=4, REFRACT_CYC=20, INTERVAL_W=8.
module tb_hartslag_puls_filter;

  localparam int D  = 4;
  localparam int R  = 20;
  localparam int IW = 8;

`ifdef HARTSLAG_INTERVAL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset = 1'b1;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int npuls = 0;
  int nverw = 0;
  int nboth = 0;
  int nig = 0;
  int nig_los = 0;
  int last_p = 0;
  int prev_p = 0;
  int last_iv = 0;

  hartslag_puls_filter_if #(.INTERVAL_W(IW)) bus ();

  hartslag_puls_filter #(
    .DEBOUNCE_CYC (D),
    .REFRACT_CYC  (R),
    .INTERVAL_W   (IW)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    cyc++;
    if (bus.Puls === 1'b1) begin
      npuls++;
      prev_p = last_p;
      last_p = cyc;
    end
    if (bus.Verworpen === 1'b1)
      nverw++;
    if (bus.Puls === 1'b1 && bus.Verworpen === 1'b1)
      nboth++;
    if (bus.IntervalGeldig === 1'b1) begin
      nig++;
      last_iv = int'(bus.Interval);
      if (bus.Puls !== 1'b1)
        nig_los++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic clr();
    npuls = 0;
    nverw = 0;
    nboth = 0;
    nig = 0;
    nig_los = 0;
    last_p = 0;
    prev_p = 0;
    last_iv = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.Ingang = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(1);
  endtask

  task automatic beat(input int hi, input int lo);
    bus.Ingang = 1'b1;
    tick(hi);
    bus.Ingang = 1'b0;
    tick(lo);
  endtask

  task automatic test_reset();
    int k;
    Reset = 1'b1;
    bus.Ingang = 1'b1;
    tick(3);
    total++;
    if (bus.Puls !== 1'b0 || bus.Niveau !== 1'b0 || bus.Verworpen !== 1'b0) begin
      bad++;
      $display("FAIL rst_out: got p=%b n=%b v=%b want 000",
               bus.Puls, bus.Niveau, bus.Verworpen);
    end
    total++;
    if (bus.Interval !== '0 || bus.IntervalGeldig !== 1'b0) begin
      bad++;
      $display("FAIL rst_iv: got iv=%0d ig=%b want 0 0",
               bus.Interval, bus.IntervalGeldig);
    end
    Reset = 1'b0;
    k = 0;
    while (bus.Puls !== 1'b1 && k < 20) begin
      tick(1);
      k++;
    end
    total++;
    if (k != 3 + D) begin
      bad++;
      $display("FAIL rst_lat: got %0d edges want %0d", k, 3 + D);
    end
    total++;
    if (bus.Niveau !== 1'b1) begin
      bad++;
      $display("FAIL rst_niv: got %b want 1", bus.Niveau);
    end
    bus.Ingang = 1'b0;
    tick(30);
  endtask

  task automatic test_glitch();
    clr();
    beat(3, 15);
    total++;
    if (npuls != 0 || nverw != 0) begin
      bad++;
      $display("FAIL glitch_cnt: got p=%0d v=%0d want 0 0", npuls, nverw);
    end
    total++;
    if (bus.Niveau !== 1'b0) begin
      bad++;
      $display("FAIL glitch_niv: got %b want 0", bus.Niveau);
    end
  endtask

  task automatic test_refractory();
    do_reset();
    clr();
    for (int i = 0; i < 4; i++)
      beat(5, 5);
    tick(20);
    total++;
    if (npuls != 2) begin
      bad++;
      $display("FAIL refr_puls: got %0d want 2", npuls);
    end
    total++;
    if (nverw != 2) begin
      bad++;
      $display("FAIL refr_verw: got %0d want 2", nverw);
    end
    total++;
    if (last_p - prev_p != 30) begin
      bad++;
      $display("FAIL refr_gap: got %0d want 30", last_p - prev_p);
    end
    total++;
    if (nboth != 0) begin
      bad++;
      $display("FAIL refr_both: got %0d want 0", nboth);
    end
  endtask

  task automatic test_interval();
    do_reset();
    clr();
    for (int i = 0; i < 3; i++)
      beat(5, 25);
    tick(10);
    total++;
    if (npuls != 3 || last_p - prev_p != 30) begin
      bad++;
      $display("FAIL iv_puls: got n=%0d gap=%0d want 3 30",
               npuls, last_p - prev_p);
    end
    total++;
    if (nig != (EN ? 2 : 0) || nig_los != 0) begin
      bad++;
      $display("FAIL iv_geldig: got %0d (los %0d) want %0d (los 0)",
               nig, nig_los, EN ? 2 : 0);
    end
    total++;
    if (last_iv != (EN ? 30 : 0)) begin
      bad++;
      $display("FAIL iv_val: got %0d want %0d", last_iv, EN ? 30 : 0);
    end
    total++;
    if (int'(bus.Interval) != (EN ? 30 : 0)) begin
      bad++;
      $display("FAIL iv_hold: got %0d want %0d",
               bus.Interval, EN ? 30 : 0);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    clr();
    bus.Ingang = 1'b1;
    tick(4);
    Reset = 1'b1;
    bus.Ingang = 1'b0;
    tick(1);
    total++;
    if (bus.Puls !== 1'b0 || bus.Niveau !== 1'b0) begin
      bad++;
      $display("FAIL abort_rst: got p=%b n=%b want 0 0",
               bus.Puls, bus.Niveau);
    end
    Reset = 1'b0;
    tick(10);
    total++;
    if (npuls != 0) begin
      bad++;
      $display("FAIL abort_deb: got %0d puls want 0", npuls);
    end
    beat(5, 5);
    total++;
    if (npuls != 1) begin
      bad++;
      $display("FAIL abort_pre: got %0d puls want 1", npuls);
    end
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    clr();
    beat(5, 10);
    total++;
    if (npuls != 1 || nverw != 0) begin
      bad++;
      $display("FAIL abort_refr: got p=%0d v=%0d want 1 0", npuls, nverw);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    clr();
    beat(5, 295);
    beat(5, 295);
    total++;
    if (npuls != 2 || last_p - prev_p != 300) begin
      bad++;
      $display("FAIL sat_puls: got n=%0d gap=%0d want 2 300",
               npuls, last_p - prev_p);
    end
    total++;
    if (nig != (EN ? 1 : 0) || last_iv != (EN ? 255 : 0)) begin
      bad++;
      $display("FAIL sat_iv: got ig=%0d iv=%0d want %0d %0d",
               nig, last_iv, EN ? 1 : 0, EN ? 255 : 0);
    end
    total++;
    if (int'(bus.Interval) != (EN ? 255 : 0)) begin
      bad++;
      $display("FAIL sat_hold: got %0d want %0d",
               bus.Interval, EN ? 255 : 0);
    end
  endtask

  initial begin
    bus.Ingang = 1'b0;
    test_reset();
    test_glitch();
    test_refractory();
    test_interval();
    test_reset_abort();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
